// File: rtl/chunked_serial_adder_if.sv
// Operand/result bundle for the chunked serial adder: request fields flow
// from the operand registers (master) to the adder (slave), results flow back.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, ci, a, b,
    input  ready, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, ci, a, b,
    output ready, done, sum, carry, overflow
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first, with the
// carry held in a register between chunks. Results register once per operation.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// RUN   | one chunk per edge, idx 0..N-1
// DONE  | one-cycle done pulse, then back to IDLE
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst,
  chunked_serial_adder_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cy;
  logic             sign_a;
  logic             sign_b;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] a_next;

  always_comb begin
    chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy};
  end

  // op_a doubles as the accumulator: operand chunks leave at the bottom while
  // result chunks enter at the top, so after N edges it holds the full result.
  generate
    if (N == 1) begin : g_single
      assign a_next = chunk_sum[CHUNK-1:0];
    end else begin : g_multi
      assign a_next = {chunk_sum[CHUNK-1:0], op_a[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      cy           <= 1'b0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      bus.sum      <= '0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.done     <= 1'b0;
      bus.ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a      <= bus.a;
            op_b      <= bus.sub ? ~bus.b : bus.b;
            cy        <= bus.sub ? 1'b1 : bus.ci;
            sign_a    <= bus.a[WIDTH-1];
            sign_b    <= bus.b[WIDTH-1] ^ bus.sub;
            idx       <= '0;
            bus.ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          op_a <= a_next;
          op_b <= op_b >> CHUNK;
          cy   <= chunk_sum[CHUNK];
          idx  <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            bus.sum      <= a_next;
            bus.carry    <= chunk_sum[CHUNK];
            bus.overflow <= (sign_a == sign_b) && (a_next[WIDTH-1] != sign_a);
            bus.done     <= 1'b1;
            idx          <= '0;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
